// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes, opcodes,
// datapath select values and the control-word layout.
package mc_ctrl_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps the FSM state to the datapath control word.
// Only FETCH looks at mem_ready, so IR/PC load exactly once per fetch.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, next-state logic and the
// reset-gated output stage around the combinational control-word decoder.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit SUPPORT_ADDI = 1'b1,
  parameter bit SUPPORT_J    = 1'b1,
  parameter bit MEM_WAIT     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] AluOP,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  logic [3:0] state, state_next;
  logic       illegal_q, illegal_next;
  logic       ready;
  ctrl_t      ctrl;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_q <= illegal_next;
    end
  end

  always_comb begin
    state_next   = S_FETCH;
    illegal_next = 1'b0;
    case (state)
      S_FETCH:  state_next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI: begin
            state_next   = SUPPORT_ADDI ? S_ADDIEX : S_FETCH;
            illegal_next = !SUPPORT_ADDI;
          end
          OP_J: begin
            state_next   = SUPPORT_J ? S_JUMP : S_FETCH;
            illegal_next = !SUPPORT_J;
          end
          default:      illegal_next = 1'b1;
        endcase
      end
      // opcode is stable in IR here; anything else would be a datapath fault
      S_MEMADR: begin
        if (opcode == OP_LW)      state_next = S_MEMRD;
        else if (opcode == OP_SW) state_next = S_MEMWR;
        else                      state_next = S_FETCH;
      end
      S_MEMRD:  state_next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_next = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (ready),
    .ctrl      (ctrl)
  );

  // Reset masks every output at once so an aborted instruction issues no writes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    AluOP       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    state_dbg   = 4'd0;
    if (!reset) begin
      PCWrite     = ctrl.pc_write;
      PCWriteCond = ctrl.pc_write_cond;
      IorD        = ctrl.iord;
      MemRead     = ctrl.mem_read;
      MemWrite    = ctrl.mem_write;
      IRWrite     = ctrl.ir_write;
      MemtoReg    = ctrl.mem_to_reg;
      RegDst      = ctrl.reg_dst;
      RegWrite    = ctrl.reg_write;
      ALUSrcA     = ctrl.alu_src_a;
      ALUSrcB     = ctrl.alu_src_b;
      AluOP       = ctrl.alu_op;
      PCSource    = ctrl.pc_source;
      illegal_op  = illegal_q;
      state_dbg   = state;
    end
  end

endmodule
